// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared states, timing defaults and pulse-width helper for the servo path
package servo_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      PULSE_X,
      PULSE_Y,
      GAP
   } state_t;

   localparam int TICK_DIV_DEF  = 10;
   localparam int FRAME_US_DEF  = 20000;
   localparam int MIN_US_DEF    = 1000;
   localparam int STEP_US_DEF   = 4;
   localparam int POS_W_DEF     = 8;
   localparam int RESET_POS_DEF = 128;

   // Tick-domain counters and widths share one width so comparisons need no casts.
   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] servo_width(input logic [CNT_W-1:0] pos,
                                                    input logic [CNT_W-1:0] min_us,
                                                    input logic [CNT_W-1:0] step_us);
      return min_us + pos * step_us;
   endfunction

endpackage

// File: rtl/servo_tick_prescaler.sv
// rtl/servo_tick_prescaler.sv - divides the system clock down to a 1 us tick strobe
module servo_tick_prescaler #(
   parameter int TICK_DIV = 10
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt <= '0;
      end else if (clr_i || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick_o = (cnt == LAST) && !clr_i;

endmodule

// File: rtl/servo_xy_frame_scheduler.sv
// rtl/servo_xy_frame_scheduler.sv - 20 ms frame scheduler driving X then Y servo pulses back-to-back
module servo_xy_frame_scheduler
   import servo_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int FRAME_US  = FRAME_US_DEF,
   parameter int MIN_US    = MIN_US_DEF,
   parameter int STEP_US   = STEP_US_DEF,
   parameter int POS_W     = POS_W_DEF,
   parameter int RESET_POS = RESET_POS_DEF
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             enable_i,
   input  logic [POS_W-1:0] pos_x_i,
   input  logic [POS_W-1:0] pos_y_i,
   input  logic             pos_valid_i,
   output logic             pos_ready_o,
   output logic             pwm_x_o,
   output logic             pwm_y_o,
   output logic             frame_start_o,
   output logic             busy_o
);

   localparam int MAX_WIDTH = MIN_US + (2**POS_W - 1) * STEP_US;

   generate
      if (FRAME_US <= 2 * MAX_WIDTH) begin : g_frame_too_short
         $error("FRAME_US must exceed two full-scale pulse widths");
      end
      if (TICK_DIV < 2 || FRAME_US >= 2**CNT_W || POS_W >= CNT_W) begin : g_bad_sizing
         $error("TICK_DIV must be >= 2 and FRAME_US/POS_W must fit the tick counter");
      end
   endgenerate

   state_t           state_q, state_d;
   logic             tick;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] width_x, width_y, end_x, end_y;
   logic [POS_W-1:0] act_x, act_y, pend_x, pend_y;
   logic             pend_full;
   logic             accept;

   servo_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clr_i     (state_q == IDLE),
      .tick_o    (tick)
   );

   assign pos_ready_o = !pend_full;
   assign accept      = pos_valid_i && !pend_full;

   // Active setpoints only change at the end of START, so widths stay fixed for the whole frame.
   assign width_x = servo_width(CNT_W'(act_x), CNT_W'(MIN_US), CNT_W'(STEP_US));
   assign width_y = servo_width(CNT_W'(act_y), CNT_W'(MIN_US), CNT_W'(STEP_US));
   assign end_x   = width_x - 1'b1;
   assign end_y   = width_x + width_y - 1'b1;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable_i) state_d = START;
         START:   state_d = PULSE_X;
         PULSE_X: if (tick && frame_cnt == end_x) state_d = PULSE_Y;
         PULSE_Y: if (tick && frame_cnt == end_y) state_d = GAP;
         GAP:     if (tick && frame_cnt == CNT_W'(FRAME_US - 1)) state_d = enable_i ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track state_q without decode glitches.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pwm_x_o       <= 1'b0;
         pwm_y_o       <= 1'b0;
         frame_start_o <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         pwm_x_o       <= (state_d == START) || (state_d == PULSE_X);
         pwm_y_o       <= (state_d == PULSE_Y);
         frame_start_o <= (state_d == START);
         busy_o        <= (state_d != IDLE);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         frame_cnt <= '0;
      end else if (state_q == IDLE || state_q == START) begin
         frame_cnt <= '0;
      end else if (tick) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         act_x     <= POS_W'(RESET_POS);
         act_y     <= POS_W'(RESET_POS);
         pend_x    <= '0;
         pend_y    <= '0;
         pend_full <= 1'b0;
      end else begin
         if (state_q == START && pend_full) begin
            act_x <= pend_x;
            act_y <= pend_y;
         end
         if (accept) begin
            pend_x    <= pos_x_i;
            pend_y    <= pos_y_i;
            pend_full <= 1'b1;
         end else if (state_q == START) begin
            pend_full <= 1'b0;
         end
      end
   end

endmodule

// File: doc/servo_xy_frame_scheduler.md
Name: servo_xy_frame_scheduler

Overview:
Frame-level scheduler for the XY RC-servo path. It owns the 20 ms servo frame and sequences the X and Y pulses back-to-back rather than overlapping them, which limits supply current peaks. Position setpoints arrive through a valid/ready handshake and are double-buffered so they take effect only at a frame boundary. It sits between the position source (comparator/tracking logic) and the pwm_pin_x/y pads of the servo core.

Parameters:
TICK_DIV, 10, clk_i cycles per 1 us tick (10 MHz clock).
FRAME_US, 20000, frame length in ticks.
MIN_US, 1000, pulse width in ticks at position 0.
STEP_US, 4, ticks per position LSB (pulse range 1000..2020 us).
POS_W, 8, setpoint width.
RESET_POS, 128, active setpoint after reset (1512 us).

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  reset, asynchronous, active-low
enable_i  in  1  run frames while high
pos_x_i  in  POS_W  X setpoint
pos_y_i  in  POS_W  Y setpoint
pos_valid_i  in  1  setpoint pair valid
pos_ready_o  out  1  pending buffer empty, pair accepted on valid&&ready
pwm_x_o  out  1  X servo pulse
pwm_y_o  out  1  Y servo pulse
frame_start_o  out  1  one-cycle pulse at frame start
busy_o  out  1  high while not in IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset is reset_n_i, asynchronous and active-low.
- Reset values:
  - pwm_x_o=0, pwm_y_o=0, frame_start_o=0, busy_o=0, pos_ready_o=1.
  - Active X and Y setpoints = RESET_POS.
  - Pending buffer empty; prescaler and frame counter cleared; state IDLE.
- Widths: width = MIN_US + pos*STEP_US, computed unsigned at >= 12 bits. FRAME_US must exceed 2*(MIN_US + (2^POS_W-1)*STEP_US); check this with an elaboration assertion.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on its last count. It is held at 0 in IDLE, so the first frame always starts tick-aligned.
- States:
  - IDLE -> START when enable_i is sampled high.
  - START lasts one cycle. It asserts frame_start_o, raises pwm_x_o, transfers pending->active if the pending buffer is full, and clears frame_cnt. Then -> PULSE_X.
  - PULSE_X: pwm_x_o high for exactly width_x*TICK_DIV cycles, counted from START. In the cycle it falls, pwm_y_o rises (zero gap, no overlap). -> PULSE_Y.
  - PULSE_Y: pwm_y_o high for width_y*TICK_DIV cycles. -> GAP.
  - GAP: both outputs low until frame_cnt reaches FRAME_US-1 on a tick. Then -> START if enable_i=1, otherwise -> IDLE.
- Frame period: exactly FRAME_US*TICK_DIV cycles, START to START.
- Widths latch at START. Setpoint changes mid-frame never alter the current pulses.
- Handshake:
  - pos_ready_o = !pending_full. Accepting a pair sets pending_full.
  - At START, a full buffer transfers to active and empties. A pair accepted in the START cycle itself goes to pending and takes effect next frame.
  - pos_valid_i while ready=0 is ignored and holds no state. The source must hold valid until ready.
  - In IDLE, accepting a pair fills pending; it is applied at the next START.
- enable_i falling mid-frame: the current frame completes (no runt pulses), then the block enters IDLE. enable_i re-rising before frame end: the next frame runs normally.
- busy_o = (state != IDLE).
- Reset mid-pulse: outputs go low immediately (asynchronous). The next frame starts from IDLE with RESET_POS.

Decomposition:
- Package servo_pkg: state enum (IDLE, START, PULSE_X, PULSE_Y, GAP), default constants for the timing parameters, and a width-computation function.
- Sub-module servo_tick_prescaler (parameter TICK_DIV; ports clr_i, tick_o), reusable by the other servo timing blocks.

Test Plan:
- Test override: TICK_DIV=2, FRAME_US=5000.
- Reset then enable_i=1 -> first frame_start_o 2 cycles after enable; pwm_x high 3024 cycles (1512 us); pwm_y rises in the same cycle x falls and stays high 3024 cycles; next START at 10000 cycles.
- Send pair (0,255) mid-frame -> pos_ready_o drops the cycle after acceptance; current frame keeps 1512/1512; next frame x=1000 us (2000 cycles), y=2020 us (4040 cycles); ready returns high the cycle after START.
- Send a second pair while pending is full -> ready=0 and the pair is not taken. Send a pair in the START cycle -> it applies one frame later.
- Drop enable_i during PULSE_Y -> pulse completes at full width, GAP completes, busy_o falls at frame end, and no further frame_start_o.
- Assert reset_n_i low during PULSE_X -> pwm_x_o low asynchronously. After release and enable, widths are 1512 us and any pending pair is discarded.
- Over many frames with random setpoints -> pwm_x_o and pwm_y_o never both high; each period is exactly 10000 cycles.
